primitive_assembler: RTL and testbench

- Downstream end of the decode stage's vertex/primitive interface.
- Consumes the one-cycle registered pulses NewVertex, StartPrimitive, EndPrimitive and Draw, plus PrimitiveType and Vertex.
- Groups vertices into points, lines and triangles, including strip and fan expansion, and queues the finished primitives in a small FIFO.
- Drives Stall back to decode when it cannot accept input, and presents primitives to the rasteriser over a valid/ready handshake.

---
 rtl/gpu_defs.sv | 38 +++
 rtl/prim_fifo.sv | 66 ++++++
 rtl/primitive_assembler.sv | 220 ++++++++++++++++++++++
 tb/tb_primitive_assembler.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_defs.sv
// Shared GPU front-end definitions: primitive group types, rasteriser
// primitive codes, vertex width, assembler states and decode opcodes.
package gpu_defs;

   localparam int VW = 64;

   typedef enum logic [3:0] {
      PT_POINTS     = 4'd0,
      PT_LINES      = 4'd1,
      PT_LINE_STRIP = 4'd2,
      PT_TRIANGLES  = 4'd3,
      PT_TRI_STRIP  = 4'd4,
      PT_TRI_FAN    = 4'd5
   } prim_type_e;

   typedef enum logic [1:0] {
      PRIM_POINT    = 2'd0,
      PRIM_LINE     = 2'd1,
      PRIM_TRIANGLE = 2'd2
   } prim_out_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ASSEMBLE = 2'd1,
      ST_DRAIN    = 2'd2
   } asm_state_e;

   localparam logic [7:0] OP_NOP    = 8'h00;
   localparam logic [7:0] OP_START  = 8'h01;
   localparam logic [7:0] OP_VERTEX = 8'h02;
   localparam logic [7:0] OP_END    = 8'h03;
   localparam logic [7:0] OP_DRAW   = 8'h04;

   function automatic logic type_is_valid(input logic [3:0] t);
      return (t <= 4'd5);
   endfunction

endpackage

// File: rtl/prim_fifo.sv
// Primitive queue with a registered head: out_data always holds the oldest
// entry (zero when empty), so consumers see register-driven outputs.
module prim_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic [WIDTH-1:0]       out_data
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
   logic [AW:0]      cnt_r, cnt_nxt_s;
   logic [WIDTH-1:0] head_r, head_nxt_s;
   logic             push_s, pop_s;

   assign full     = (cnt_r == (AW+1)'(DEPTH));
   assign empty    = (cnt_r == '0);
   assign count    = cnt_r;
   assign out_data = head_r;
   assign push_s   = push && !full;
   assign pop_s    = pop && !empty;

   // Next occupancy, read pointer and head value after this cycle's push/pop.
   always_comb begin
      cnt_nxt_s    = cnt_r + (AW+1)'(push_s) - (AW+1)'(pop_s);
      rd_ptr_nxt_s = rd_ptr_r + AW'(pop_s);
      if (cnt_nxt_s == '0) begin
         head_nxt_s = '0;
      end else if (cnt_r == (AW+1)'(pop_s)) begin
         head_nxt_s = push_data;
      end else begin
         head_nxt_s = mem_r[rd_ptr_nxt_s];
      end
   end

   // Storage, pointers and head register.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= '0;
         head_r   <= '0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         rd_ptr_r <= rd_ptr_nxt_s;
         cnt_r    <= cnt_nxt_s;
         head_r   <= head_nxt_s;
      end
   end

endmodule

// File: rtl/primitive_assembler.sv
// Primitive assembler: groups decoded vertices into points, lines and
// triangles (including strips and fans) and queues them for the rasteriser.
module primitive_assembler #(
   parameter int DEPTH = 4,
   parameter int VW    = gpu_defs::VW
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          NewVertex,
   input  logic [VW-1:0] Vertex,
   input  logic          StartPrimitive,
   input  logic [3:0]    PrimitiveType,
   input  logic          EndPrimitive,
   input  logic          Draw,
   output logic          Stall,
   output logic          Prim_Valid,
   input  logic          Prim_Ready,
   output logic [1:0]    Prim_Type,
   output logic [VW-1:0] Prim_V0,
   output logic [VW-1:0] Prim_V1,
   output logic [VW-1:0] Prim_V2,
   output logic          Draw_Done,
   output logic          Error
);
   import gpu_defs::*;

   localparam int EW = 2 + 3*VW;
   localparam int CW = $clog2(DEPTH) + 1;

   asm_state_e    state_r, state_nxt_s;
   logic [3:0]    type_r, type_nxt_s;
   logic [1:0]    cnt_r, cnt_nxt_s, cnt_inc_s;
   logic          par_r, par_nxt_s;
   logic          type_bad_r, type_bad_nxt_s;
   logic          error_r, error_nxt_s;
   logic          done_r, done_nxt_s;
   logic [VW-1:0] hist_b_r, hist_b_nxt_s;
   logic [VW-1:0] hist_c_r, hist_c_nxt_s;
   logic [VW-1:0] pivot_r, pivot_nxt_s;
   logic          push_s;
   logic [1:0]    ptype_s;
   logic [VW-1:0] pv0_s, pv1_s, pv2_s;
   logic          fifo_full_s, fifo_empty_s;
   logic [CW-1:0] fifo_count_s;
   logic [EW-1:0] fifo_out_s;

   assign Stall      = fifo_full_s || (state_r == ST_DRAIN);
   assign Prim_Valid = !fifo_empty_s;
   assign {Prim_Type, Prim_V0, Prim_V1, Prim_V2} = fifo_out_s;
   assign Draw_Done  = done_r;
   assign Error      = error_r;
   assign cnt_inc_s  = (cnt_r == 2'd3) ? 2'd3 : cnt_r + 2'd1;

   // Next-state, vertex history and primitive emission; only unstalled cycles count.
   always_comb begin
      state_nxt_s    = state_r;
      type_nxt_s     = type_r;
      cnt_nxt_s      = cnt_r;
      par_nxt_s      = par_r;
      type_bad_nxt_s = type_bad_r;
      error_nxt_s    = error_r;
      done_nxt_s     = 1'b0;
      hist_b_nxt_s   = hist_b_r;
      hist_c_nxt_s   = hist_c_r;
      pivot_nxt_s    = pivot_r;
      push_s         = 1'b0;
      ptype_s        = PRIM_POINT;
      pv0_s          = '0;
      pv1_s          = '0;
      pv2_s          = '0;
      if (state_r == ST_DRAIN) begin
         if ((fifo_count_s == '0) && !Prim_Valid) begin
            done_nxt_s  = 1'b1;
            state_nxt_s = ST_IDLE;
         end else begin
            done_nxt_s  = 1'b0;
         end
      end else if (Stall) begin
         done_nxt_s = 1'b0;
      end else if (Draw) begin
         state_nxt_s = ST_DRAIN;
         cnt_nxt_s   = 2'd0;
         par_nxt_s   = 1'b0;
      end else if (EndPrimitive) begin
         if (state_r == ST_IDLE) begin
            error_nxt_s = 1'b1;
         end else begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 2'd0;
         end
      end else if (StartPrimitive) begin
         state_nxt_s    = ST_ASSEMBLE;
         type_nxt_s     = PrimitiveType;
         cnt_nxt_s      = 2'd0;
         par_nxt_s      = 1'b0;
         type_bad_nxt_s = !type_is_valid(PrimitiveType);
         error_nxt_s    = error_r || (state_r == ST_ASSEMBLE) || !type_is_valid(PrimitiveType);
      end else if (NewVertex) begin
         if (state_r != ST_ASSEMBLE) begin
            error_nxt_s = 1'b1;
         end else if (type_bad_r) begin
            cnt_nxt_s = cnt_r;
         end else begin
            hist_b_nxt_s = hist_c_r;
            hist_c_nxt_s = Vertex;
            cnt_nxt_s    = cnt_inc_s;
            case (type_r)
               PT_POINTS: begin
                  push_s = 1'b1;
                  pv0_s  = Vertex;
               end
               PT_LINES: begin
                  if (cnt_r == 2'd1) begin
                     push_s    = 1'b1;
                     ptype_s   = PRIM_LINE;
                     pv0_s     = hist_c_r;
                     pv1_s     = Vertex;
                     cnt_nxt_s = 2'd0;
                  end else begin
                     push_s = 1'b0;
                  end
               end
               PT_LINE_STRIP: begin
                  if (cnt_r != 2'd0) begin
                     push_s  = 1'b1;
                     ptype_s = PRIM_LINE;
                     pv0_s   = hist_c_r;
                     pv1_s   = Vertex;
                  end else begin
                     push_s = 1'b0;
                  end
               end
               PT_TRIANGLES: begin
                  if (cnt_r == 2'd2) begin
                     push_s    = 1'b1;
                     ptype_s   = PRIM_TRIANGLE;
                     pv0_s     = hist_b_r;
                     pv1_s     = hist_c_r;
                     pv2_s     = Vertex;
                     cnt_nxt_s = 2'd0;
                  end else begin
                     push_s = 1'b0;
                  end
               end
               PT_TRI_STRIP: begin
                  // Odd triangles swap the first two vertices to keep a consistent winding.
                  if (cnt_r >= 2'd2) begin
                     push_s    = 1'b1;
                     ptype_s   = PRIM_TRIANGLE;
                     pv0_s     = par_r ? hist_c_r : hist_b_r;
                     pv1_s     = par_r ? hist_b_r : hist_c_r;
                     pv2_s     = Vertex;
                     par_nxt_s = !par_r;
                  end else begin
                     push_s = 1'b0;
                  end
               end
               PT_TRI_FAN: begin
                  pivot_nxt_s = (cnt_r == 2'd0) ? Vertex : pivot_r;
                  if (cnt_r >= 2'd2) begin
                     push_s  = 1'b1;
                     ptype_s = PRIM_TRIANGLE;
                     pv0_s   = pivot_r;
                     pv1_s   = hist_c_r;
                     pv2_s   = Vertex;
                  end else begin
                     push_s = 1'b0;
                  end
               end
               default: push_s = 1'b0;
            endcase
         end
      end else begin
         done_nxt_s = 1'b0;
      end
   end

   // Assembler state registers.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_r    <= ST_IDLE;
         type_r     <= 4'd0;
         cnt_r      <= 2'd0;
         par_r      <= 1'b0;
         type_bad_r <= 1'b0;
         error_r    <= 1'b0;
         done_r     <= 1'b0;
         hist_b_r   <= '0;
         hist_c_r   <= '0;
         pivot_r    <= '0;
      end else begin
         state_r    <= state_nxt_s;
         type_r     <= type_nxt_s;
         cnt_r      <= cnt_nxt_s;
         par_r      <= par_nxt_s;
         type_bad_r <= type_bad_nxt_s;
         error_r    <= error_nxt_s;
         done_r     <= done_nxt_s;
         hist_b_r   <= hist_b_nxt_s;
         hist_c_r   <= hist_c_nxt_s;
         pivot_r    <= pivot_nxt_s;
      end
   end

   prim_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK       (CLK),
      .RESET     (RESET),
      .push      (push_s),
      .push_data ({ptype_s, pv0_s, pv1_s, pv2_s}),
      .pop       (Prim_Valid && Prim_Ready),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count_s),
      .out_data  (fifo_out_s)
   );

endmodule

// File: tb/tb_primitive_assembler.sv
// Directed bench for primitive_assembler: decode-side driver honouring Stall,
// a pop monitor, and per-scenario tasks with hand-computed expectations.
module tb_primitive_assembler;

   typedef struct packed {
      logic [1:0]  t;
      logic [63:0] v0;
      logic [63:0] v1;
      logic [63:0] v2;
   } prim_t;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        NewVertex = 1'b0;
   logic [63:0] Vertex = 64'd0;
   logic        StartPrimitive = 1'b0;
   logic [3:0]  PrimitiveType = 4'd0;
   logic        EndPrimitive = 1'b0;
   logic        Draw = 1'b0;
   logic        Stall;
   logic        Prim_Valid;
   logic        Prim_Ready = 1'b0;
   logic [1:0]  Prim_Type;
   logic [63:0] Prim_V0, Prim_V1, Prim_V2;
   logic        Draw_Done;
   logic        Error;

   int pass_cnt  = 0;
   int total_cnt = 0;
   prim_t got_q[$];

   primitive_assembler #(.DEPTH(4), .VW(64)) dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .NewVertex      (NewVertex),
      .Vertex         (Vertex),
      .StartPrimitive (StartPrimitive),
      .PrimitiveType  (PrimitiveType),
      .EndPrimitive   (EndPrimitive),
      .Draw           (Draw),
      .Stall          (Stall),
      .Prim_Valid     (Prim_Valid),
      .Prim_Ready     (Prim_Ready),
      .Prim_Type      (Prim_Type),
      .Prim_V0        (Prim_V0),
      .Prim_V1        (Prim_V1),
      .Prim_V2        (Prim_V2),
      .Draw_Done      (Draw_Done),
      .Error          (Error)
   );

   always #5 CLK = ~CLK;

   // Record every primitive that will be popped on the coming posedge.
   always begin
      @(negedge CLK);
      #1;
      if (!RESET && Prim_Valid && Prim_Ready)
         got_q.push_back({Prim_Type, Prim_V0, Prim_V1, Prim_V2});
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1);
   end

   // Decode-style pulse: hold inputs while Stall=1, release after the accepting edge.
   task automatic drive(input logic nv, input logic sp, input logic ep, input logic dr,
                        input logic [3:0] pt, input logic [63:0] v);
      int guard;
      guard = 0;
      NewVertex = nv; StartPrimitive = sp; EndPrimitive = ep; Draw = dr;
      PrimitiveType = pt; Vertex = v;
      while (Stall && guard < 100) begin
         @(negedge CLK);
         guard++;
      end
      total_cnt++;
      if (guard >= 100) $display("FAIL stall_timeout: waited %0d cycles, required < 100", guard);
      else pass_cnt++;
      @(negedge CLK);
      NewVertex = 1'b0; StartPrimitive = 1'b0; EndPrimitive = 1'b0; Draw = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic test_reset;
      idle(2);
      total_cnt++;
      if ({Stall, Prim_Valid, Draw_Done, Error} !== 4'b0000)
         $display("FAIL reset_flags: got %b required 0000", {Stall, Prim_Valid, Draw_Done, Error});
      else pass_cnt++;
      total_cnt++;
      if ({Prim_Type, Prim_V0, Prim_V1, Prim_V2} !== 194'd0)
         $display("FAIL reset_prim: got %h required 0", {Prim_Type, Prim_V0, Prim_V1, Prim_V2});
      else pass_cnt++;
      RESET = 1'b0;
      idle(1);
      total_cnt++;
      if ({Stall, Prim_Valid} !== 2'b00)
         $display("FAIL post_reset_idle: got %b required 00", {Stall, Prim_Valid});
      else pass_cnt++;
   endtask

   task automatic test_points;
      Prim_Ready = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 64'd0);
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 64'(i));
         total_cnt++;
         if ({Prim_Valid, Prim_Type, Prim_V0, Prim_V1, Prim_V2} !== {1'b1, 2'd0, 64'(i), 64'd0, 64'd0})
            $display("FAIL points_v%0d: got valid=%b type=%0d v0=%h v1=%h v2=%h required valid=1 type=0 v0=%h v1=0 v2=0",
                     i, Prim_Valid, Prim_Type, Prim_V0, Prim_V1, Prim_V2, 64'(i));
         else pass_cnt++;
      end
      drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 64'd0);
      total_cnt++;
      if (Prim_Valid !== 1'b0) $display("FAIL points_drained: got valid=%b required 0", Prim_Valid);
      else pass_cnt++;
   endtask

   task automatic test_tri_strip;
      prim_t exp_a [3];
      exp_a[0] = {2'd2, 64'd10, 64'd11, 64'd12};
      exp_a[1] = {2'd2, 64'd12, 64'd11, 64'd13};
      exp_a[2] = {2'd2, 64'd12, 64'd13, 64'd14};
      got_q.delete();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 64'd0);
      for (int i = 10; i <= 14; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 64'(i));
      drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 64'd0);
      idle(3);
      total_cnt++;
      if (got_q.size() != 3) $display("FAIL strip_count: got %0d required 3", got_q.size());
      else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         total_cnt++;
         if (got_q.size() <= i || got_q[i] !== exp_a[i])
            $display("FAIL strip_tri%0d: got %h required %h", i, (got_q.size() > i) ? got_q[i] : '0, exp_a[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_tri_fan;
      prim_t exp_a [3];
      exp_a[0] = {2'd2, 64'd1, 64'd2, 64'd3};
      exp_a[1] = {2'd2, 64'd1, 64'd3, 64'd4};
      exp_a[2] = {2'd2, 64'd1, 64'd4, 64'd5};
      got_q.delete();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 64'd0);
      for (int i = 1; i <= 5; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 64'(i));
      drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 64'd0);
      idle(3);
      total_cnt++;
      if (got_q.size() != 3) $display("FAIL fan_count: got %0d required 3", got_q.size());
      else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         total_cnt++;
         if (got_q.size() <= i || got_q[i] !== exp_a[i])
            $display("FAIL fan_tri%0d: got %h required %h", i, (got_q.size() > i) ? got_q[i] : '0, exp_a[i]);
         else pass_cnt++;
      end
      got_q.delete();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 64'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 64'd6);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 64'd7);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 64'd0);
      idle(3);
      total_cnt++;
      if (got_q.size() != 0 || Error !== 1'b0)
         $display("FAIL tri_partial_end: got count=%0d error=%b required count=0 error=0", got_q.size(), Error);
      else pass_cnt++;
   endtask

   task automatic test_backpressure;
      got_q.delete();
      Prim_Ready = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 64'd0);
      for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 64'(i));
      total_cnt++;
      if ({Stall, Prim_Valid, Prim_V0} !== {1'b1, 1'b1, 64'd1})
         $display("FAIL bp_full: got stall=%b valid=%b v0=%h required stall=1 valid=1 v0=1", Stall, Prim_Valid, Prim_V0);
      else pass_cnt++;
      fork
         drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 64'd5);
         begin
            idle(3);
            total_cnt++;
            if ({Stall, Prim_V0} !== {1'b1, 64'd1})
               $display("FAIL bp_hold: got stall=%b v0=%h required stall=1 v0=1", Stall, Prim_V0);
            else pass_cnt++;
            Prim_Ready = 1'b1;
         end
      join
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 64'd6);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 64'd0);
      idle(6);
      total_cnt++;
      if (got_q.size() != 6) $display("FAIL bp_count: got %0d required 6", got_q.size());
      else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         total_cnt++;
         if (got_q.size() <= i || got_q[i] !== {2'd0, 64'(i + 1), 64'd0, 64'd0})
            $display("FAIL bp_order%0d: got %h required v0=%0d", i, (got_q.size() > i) ? got_q[i] : '0, i + 1);
         else pass_cnt++;
      end
   endtask

   task automatic test_draw;
      int empty_idx, done_idx, done_cnt;
      logic stall_at_empty;
      empty_idx = -1; done_idx = -1; done_cnt = 0; stall_at_empty = 1'b0;
      got_q.delete();
      Prim_Ready = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 64'd0);
      for (int i = 7; i <= 9; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 64'(i));
      drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 64'd0);
      total_cnt++;
      if ({Stall, Prim_Valid} !== 2'b11)
         $display("FAIL draw_stall: got stall=%b valid=%b required 1 1", Stall, Prim_Valid);
      else pass_cnt++;
      Prim_Ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         if (!Prim_Valid && empty_idx < 0) begin
            empty_idx = i;
            stall_at_empty = Stall;
         end
         if (Draw_Done === 1'b1) begin
            done_cnt++;
            done_idx = i;
         end
      end
      total_cnt++;
      if (done_cnt != 1) $display("FAIL draw_done_count: got %0d required 1", done_cnt);
      else pass_cnt++;
      total_cnt++;
      if (empty_idx != 2 || done_idx != empty_idx + 1)
         $display("FAIL draw_done_timing: got empty=%0d done=%0d required empty=2 done=3", empty_idx, done_idx);
      else pass_cnt++;
      total_cnt++;
      if (stall_at_empty !== 1'b1 || Stall !== 1'b0)
         $display("FAIL draw_stall_release: got at_empty=%b after=%b required 1 0", stall_at_empty, Stall);
      else pass_cnt++;
      total_cnt++;
      if (got_q.size() != 3 || got_q[0].v0 !== 64'd7 || got_q[1].v0 !== 64'd8 || got_q[2].v0 !== 64'd9)
         $display("FAIL draw_flush_data: got count=%0d required 3 entries 7,8,9", got_q.size());
      else pass_cnt++;
   endtask

   task automatic test_errors;
      total_cnt++;
      if (Error !== 1'b0) $display("FAIL err_clean: got %b required 0", Error);
      else pass_cnt++;
      got_q.delete();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 64'hAA);
      total_cnt++;
      if (Error !== 1'b1) $display("FAIL err_vertex_idle: got %b required 1", Error);
      else pass_cnt++;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 64'd0);
      for (int i = 1; i <= 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 64'(i));
      drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 64'd0);
      idle(4);
      total_cnt++;
      if (got_q.size() != 0 || Error !== 1'b1)
         $display("FAIL err_bad_type: got count=%0d error=%b required count=0 error=1", got_q.size(), Error);
      else pass_cnt++;
      Prim_Ready = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 64'd0);
      for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 64'(i));
      total_cnt++;
      if (Prim_Valid !== 1'b1) $display("FAIL rst_pre_valid: got %b required 1", Prim_Valid);
      else pass_cnt++;
      #2 RESET = 1'b1;
      #1;
      total_cnt++;
      if ({Stall, Prim_Valid, Draw_Done, Error} !== 4'b0000)
         $display("FAIL rst_async_flags: got %b required 0000", {Stall, Prim_Valid, Draw_Done, Error});
      else pass_cnt++;
      total_cnt++;
      if ({Prim_Type, Prim_V0, Prim_V1, Prim_V2} !== 194'd0)
         $display("FAIL rst_async_prim: got %h required 0", {Prim_Type, Prim_V0, Prim_V1, Prim_V2});
      else pass_cnt++;
      @(negedge CLK);
      RESET = 1'b0;
      Prim_Ready = 1'b1;
      got_q.delete();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 64'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 64'h55);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 64'd0);
      idle(3);
      total_cnt++;
      if (got_q.size() != 1 || got_q[0] !== {2'd0, 64'h55, 64'd0, 64'd0})
         $display("FAIL rst_fifo_cleared: got count=%0d first=%h required count=1 first v0=55",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : '0);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_points();
      test_tri_strip();
      test_tri_fan();
      test_backpressure();
      test_draw();
      test_errors();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
